// File: rtl/ascon_fifo_pkg.sv
// Shared definitions for the Ascon result FIFO: byte width, block-to-byte helper
// and the drain FSM state type.
package ascon_fifo_pkg;

  localparam int BYTE_W = 8;

  function automatic int f_bytes(input int width);
    return width / BYTE_W;
  endfunction

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_DRAIN = 1'b1
  } drain_state_e;

endpackage

// File: rtl/ascon_fifo_byte_sel.sv
// Combinational byte selector: picks byte byte_idx (byte 0 = MSB) of the head
// block, or 8'h00 when the FIFO holds nothing.
module ascon_fifo_byte_sel
  import ascon_fifo_pkg::*;
#(
  parameter int pBLOCK_WIDTH = 128,
  parameter int pIDX_WIDTH   = 4
) (
  input  logic [pBLOCK_WIDTH-1:0] head,
  input  logic [pIDX_WIDTH-1:0]   byte_idx,
  input  logic                    empty,
  output logic [BYTE_W-1:0]       rd_byte
);

  localparam int NBYTES = f_bytes(pBLOCK_WIDTH);

  always_comb begin
    // NOTE: defaulting every always_comb output first keeps the mux free of inferred latches.
    rd_byte = '0;
    if (!empty) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (int'(byte_idx) == i) rd_byte = head[pBLOCK_WIDTH-1-BYTE_W*i -: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/ascon_result_fifo.sv
// Block-wide result FIFO drained byte-serially, MSB first, with flush and sticky
// overflow. Define ASCON_FIFO_DROP_CNT_EN to add the saturating drop_cnt port.
module ascon_result_fifo
  import ascon_fifo_pkg::*;
#(
  parameter int pBLOCK_WIDTH = 128,
  parameter int pDEPTH       = 8,
  parameter int pCNT_WIDTH   = $clog2(pDEPTH) + 1
) (
  input  logic                    crypt_clk,
  input  logic                    resetn,
  input  logic                    flush,
  input  logic                    wr_valid,
  input  logic [pBLOCK_WIDTH-1:0] wr_data,
  output logic                    wr_ready,
  output logic [BYTE_W-1:0]       rd_byte,
  input  logic                    rd_ack,
  output logic [pCNT_WIDTH-1:0]   count,
  output logic                    empty,
  output logic                    full,
  input  logic                    overflow_clr,
  output logic                    overflow
`ifdef ASCON_FIFO_DROP_CNT_EN
  ,
  output logic [15:0]             drop_cnt
`endif
);

  localparam int NBYTES = f_bytes(pBLOCK_WIDTH);
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int PTR_W  = $clog2(pDEPTH);

  if ((pBLOCK_WIDTH % BYTE_W) != 0 || pBLOCK_WIDTH < BYTE_W ||
      pDEPTH < 2 || (pDEPTH & (pDEPTH - 1)) != 0) begin : g_param_check
    $error("ascon_result_fifo: pBLOCK_WIDTH must be a multiple of 8, pDEPTH a power of 2 >= 2");
  end

  logic [pBLOCK_WIDTH-1:0] mem [pDEPTH];
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;
  logic [IDX_W-1:0]        byte_idx;
  drain_state_e            state;
  logic                    last_byte, push, drop, advance, pop;
  logic [pCNT_WIDTH-1:0]   count_next;

  // A push is judged against the registered full, so a same-cycle pop never rescues it.
  assign last_byte = (byte_idx == IDX_W'(NBYTES - 1));
  assign push      = wr_valid & ~full & ~flush;
  assign drop      = wr_valid & full & ~flush;
  assign advance   = rd_ack & ~empty & ~flush;
  assign pop       = advance & last_byte;
  assign wr_ready  = ~full;
  assign empty     = (state == ST_IDLE);

  always_comb begin
    count_next = count;
    if (flush)              count_next = '0;
    else if (push && !pop)  count_next = count + 1'b1;
    else if (pop && !push)  count_next = count - 1'b1;
  end

  // NOTE: the storage array has no reset; empty gates rd_byte until an entry is written.
  always_ff @(posedge crypt_clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge crypt_clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      byte_idx <= '0;
      count    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
      state    <= ST_IDLE;
    end else begin
      if (flush) begin
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        byte_idx <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (advance) begin
          if (last_byte) begin
            rd_ptr   <= rd_ptr + 1'b1;
            byte_idx <= '0;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
      end
      count <= count_next;
      full  <= (count_next == pCNT_WIDTH'(pDEPTH));

      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;

      case (state)
        ST_IDLE:  if (push) state <= ST_DRAIN;
        ST_DRAIN: if (flush || (pop && count == pCNT_WIDTH'(1) && !push)) state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef ASCON_FIFO_DROP_CNT_EN
  always_ff @(posedge crypt_clk or negedge resetn) begin
    if (!resetn)                         drop_cnt <= '0;
    else if (drop && overflow_clr)       drop_cnt <= 16'd1;
    else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    else if (overflow_clr)               drop_cnt <= '0;
  end
`endif

  ascon_fifo_byte_sel #(
    .pBLOCK_WIDTH (pBLOCK_WIDTH),
    .pIDX_WIDTH   (IDX_W)
  ) u_byte_sel (
    .head     (mem[rd_ptr]),
    .byte_idx (byte_idx),
    .empty    (empty),
    .rd_byte  (rd_byte)
  );

endmodule

// File: tb/tb_ascon_result_fifo.sv
// Directed self-checking bench for ascon_result_fifo: default 128x8 instance plus
// a 64x4 variant for the single-block drain.
module tb_ascon_result_fifo;

  logic         crypt_clk;
  logic         resetn;
  logic         flush, wr_valid, rd_ack, overflow_clr;
  logic [127:0] wr_data;
  logic         wr_ready, empty, full, overflow;
  logic [7:0]   rd_byte;
  logic [3:0]   count;
`ifdef ASCON_FIFO_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  logic         s_flush, s_wr_valid, s_rd_ack, s_overflow_clr;
  logic [63:0]  s_wr_data;
  logic         s_wr_ready, s_empty, s_full, s_overflow;
  logic [7:0]   s_rd_byte;
  logic [2:0]   s_count;
`ifdef ASCON_FIFO_DROP_CNT_EN
  logic [15:0]  s_drop_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  ascon_result_fifo u_dut (
    .crypt_clk    (crypt_clk),
    .resetn       (resetn),
    .flush        (flush),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_byte      (rd_byte),
    .rd_ack       (rd_ack),
    .count        (count),
    .empty        (empty),
    .full         (full),
    .overflow_clr (overflow_clr),
    .overflow     (overflow)
`ifdef ASCON_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  ascon_result_fifo #(
    .pBLOCK_WIDTH (64),
    .pDEPTH       (4)
  ) u_dut64 (
    .crypt_clk    (crypt_clk),
    .resetn       (resetn),
    .flush        (s_flush),
    .wr_valid     (s_wr_valid),
    .wr_data      (s_wr_data),
    .wr_ready     (s_wr_ready),
    .rd_byte      (s_rd_byte),
    .rd_ack       (s_rd_ack),
    .count        (s_count),
    .empty        (s_empty),
    .full         (s_full),
    .overflow_clr (s_overflow_clr),
    .overflow     (s_overflow)
`ifdef ASCON_FIFO_DROP_CNT_EN
    ,
    .drop_cnt     (s_drop_cnt)
`endif
  );

  initial crypt_clk = 1'b0;
  always #5 crypt_clk = ~crypt_clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 ns after it.
  task automatic step();
    @(posedge crypt_clk);
    #1;
  endtask

  task automatic push(input logic [127:0] data);
    wr_valid = 1'b1;
    wr_data  = data;
    step();
    wr_valid = 1'b0;
  endtask

  // Expected byte k (0 = MSB) of a 128-bit block, by shifting it to the top.
  function automatic logic [7:0] exp_byte(input logic [127:0] data, input int k);
    logic [127:0] t;
    t = data << (8 * k);
    return t[127:120];
  endfunction

  task automatic drain_block(input string tag, input logic [127:0] data);
    for (int k = 0; k < 16; k++) begin
      check(tag, rd_byte, exp_byte(data, k));
      rd_ack = 1'b1;
      step();
      rd_ack = 1'b0;
    end
  endtask

  localparam logic [127:0] VEC = 128'h8a278bf8fa2812bc39e52c76205af377;

  initial begin
    logic [63:0] t64;
    resetn = 1'b1;
    {flush, wr_valid, rd_ack, overflow_clr} = '0;
    {s_flush, s_wr_valid, s_rd_ack, s_overflow_clr} = '0;
    wr_data = '0;
    s_wr_data = '0;
    #2 resetn = 1'b0;
    #1;
    check("rst_count", 128'(count), 128'd0);
    check("rst_empty", 128'(empty), 128'd1);
    check("rst_full", 128'(full), 128'd0);
    check("rst_wr_ready", 128'(wr_ready), 128'd1);
    check("rst_overflow", 128'(overflow), 128'd0);
    check("rst_rd_byte", 128'(rd_byte), 128'h00);
`ifdef ASCON_FIFO_DROP_CNT_EN
    check("rst_drop_cnt", 128'(drop_cnt), 128'd0);
`endif
    step();
    step();
    resetn = 1'b1;
    step();

    // Single block, MSB first.
    push(VEC);
    check("single_count", 128'(count), 128'd1);
    check("single_empty", 128'(empty), 128'd0);
    check("single_first", 128'(rd_byte), 128'h8a);
    drain_block("single_byte", VEC);
    check("single_empty_after", 128'(empty), 128'd1);
    check("single_rd_byte_after", 128'(rd_byte), 128'h00);

    // Ack while empty changes nothing.
    rd_ack = 1'b1;
    step();
    rd_ack = 1'b0;
    check("ack_empty_count", 128'(count), 128'd0);

    // Fill and overflow.
    for (int i = 1; i <= 8; i++) push(128'(i));
    check("fill_full", 128'(full), 128'd1);
    check("fill_wr_ready", 128'(wr_ready), 128'd0);
    check("fill_count", 128'(count), 128'd8);
    check("fill_no_ovf", 128'(overflow), 128'd0);
    push(128'd9);
    check("ovf_set", 128'(overflow), 128'd1);
    check("ovf_count", 128'(count), 128'd8);
`ifdef ASCON_FIFO_DROP_CNT_EN
    check("ovf_drop_cnt", 128'(drop_cnt), 128'd1);
`endif
    for (int i = 1; i <= 8; i++) drain_block("fill_drain", 128'(i));
    check("fill_empty_after", 128'(empty), 128'd1);
    check("ovf_sticky", 128'(overflow), 128'd1);
    overflow_clr = 1'b1;
    step();
    overflow_clr = 1'b0;
    check("ovf_clr", 128'(overflow), 128'd0);

    // Wrap-around: 5 rounds of 3 pushes / 3 drains.
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < 3; j++) push(128'h100 + 128'(r * 3 + j));
      check("wrap_count", 128'(count), 128'd3);
      for (int j = 0; j < 3; j++) drain_block("wrap_drain", 128'h100 + 128'(r * 3 + j));
    end
    check("wrap_empty", 128'(empty), 128'd1);

    // Simultaneous last-byte pop and push at count 4.
    for (int i = 0; i < 4; i++) push({32'hA5A5_0000 + 32'(i), 96'h0});
    for (int k = 0; k < 15; k++) begin
      rd_ack = 1'b1;
      step();
    end
    wr_valid = 1'b1;
    wr_data  = 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF;
    step();
    wr_valid = 1'b0;
    rd_ack   = 1'b0;
    check("simul_count", 128'(count), 128'd4);
    for (int i = 1; i < 4; i++) drain_block("simul_order", {32'hA5A5_0000 + 32'(i), 96'h0});
    drain_block("simul_new", 128'hE0E1E2E3E4E5E6E7E8E9EAEBECEDEEEF);
    check("simul_empty", 128'(empty), 128'd1);

    // Flush mid-drain with a concurrent push; overflow set beforehand must survive.
    for (int i = 0; i < 9; i++) push(128'hF00 + 128'(i));
    check("flush_pre_ovf", 128'(overflow), 128'd1);
    for (int k = 0; k < 5; k++) begin
      rd_ack = 1'b1;
      step();
    end
    rd_ack = 1'b0;
    check("flush_pre_byte5", 128'(rd_byte), 128'h00);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 128'hDEAD;
    step();
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_count", 128'(count), 128'd0);
    check("flush_empty", 128'(empty), 128'd1);
    check("flush_full", 128'(full), 128'd0);
    check("flush_ovf_kept", 128'(overflow), 128'd1);
    check("flush_rd_byte", 128'(rd_byte), 128'h00);
    push(VEC);
    check("flush_new_count", 128'(count), 128'd1);
    drain_block("flush_idx0", VEC);

    // Asynchronous reset with three blocks queued.
    for (int i = 0; i < 3; i++) push(128'hC0DE0000 + 128'(i));
    check("mid_count", 128'(count), 128'd3);
    #2 resetn = 1'b0;
    #1;
    check("arst_count", 128'(count), 128'd0);
    check("arst_empty", 128'(empty), 128'd1);
    check("arst_full", 128'(full), 128'd0);
    check("arst_wr_ready", 128'(wr_ready), 128'd1);
    check("arst_overflow", 128'(overflow), 128'd0);
    check("arst_rd_byte", 128'(rd_byte), 128'h00);
    step();
    resetn = 1'b1;
    step();

    // 64-bit, 4-deep variant: single block.
    s_wr_valid = 1'b1;
    s_wr_data  = 64'h8a278bf8fa2812bc;
    step();
    s_wr_valid = 1'b0;
    check("v64_count", 128'(s_count), 128'd1);
    t64 = 64'h8a278bf8fa2812bc;
    for (int k = 0; k < 8; k++) begin
      check("v64_byte", 128'(s_rd_byte), 128'(t64[63:56]));
      t64 = t64 << 8;
      s_rd_ack = 1'b1;
      step();
      s_rd_ack = 1'b0;
    end
    check("v64_empty", 128'(s_empty), 128'd1);
    check("v64_rd_byte", 128'(s_rd_byte), 128'h00);
    for (int i = 0; i < 4; i++) begin
      s_wr_valid = 1'b1;
      s_wr_data  = 64'(i);
      step();
    end
    s_wr_valid = 1'b0;
    check("v64_full", 128'(s_full), 128'd1);
    check("v64_count4", 128'(s_count), 128'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
